bnn_line_window: RTL and testbench
==================================

Name: bnn_line_window

Overview:
- Parametrised streaming line buffer. Turns a raster-order pixel stream into a KxK sliding window for the binary convolution engine.
- Generalises the fixed 3-tap, two-width shift window:
  - full KxK window instead of one tap column;
  - runtime line width and frame height;
  - multi-bit or multi-channel pixels;
  - row/column tracking with a window-valid strobe and end-of-frame pulse.
- Sits between the feature-map reader and the XNOR/popcount array.

Parameters:
- CH, 1: bits per pixel (packed channels).
- K, 3: window size, KxK, K>=2.
- MAX_W, 28: maximum line width in pixels.
- MAX_H, 28: maximum frame height in rows.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- clear  in  1  synchronous soft reset: counters to 0, frame aborted.
- cfg_width  in  $clog2(MAX_W+1)  line width W.
- cfg_height  in  $clog2(MAX_H+1)  frame height H.
- in_valid  in  1  pixel strobe; no backpressure.
- din  in  CH  pixel.
- win  out  K*K*CH  window; element (r,c) at bits [((r*K)+c)*CH +: CH]; r=0 is the top (oldest) row, c=0 is the left column.
- win_valid  out  1  one-cycle strobe: win holds a complete in-frame window.
- frame_done  out  1  one-cycle strobe: last pixel of the frame was accepted.
- busy  out  1  frame in progress (at least one pixel accepted, frame not done).
- cfg_err  out  1  latched config invalid.

Behaviour:
- Reset (rstn low, asynchronous): win=0, win_valid=0, frame_done=0, busy=0, cfg_err=0, row=col=0, delay chain all 0.
- Storage: one delay chain of (K-1)*MAX_W+K entries, each CH bits.
  - chain[0] is the newest pixel.
  - The whole chain shifts by one on each accepted pixel only; it is frozen while in_valid=0.
- Config latch:
  - cfg_width/cfg_height are sampled into W/H when busy=0, i.e. on the first accepted pixel of a frame.
  - Changes while busy=1 are ignored.
- Config check:
  - Config is invalid if W<K, W>MAX_W, H<K or H>MAX_H.
  - On an invalid config: cfg_err=1, the pixel is dropped, nothing shifts, busy stays 0.
  - cfg_err stays 1 until the next pixel arrives with a valid config, or until clear.
- Accept:
  - On an accepted pixel at position (row,col), chain shifts, then col increments.
  - At col==W-1: col wraps to 0 and row increments.
  - At row==H-1 and col==W-1: row=col=0, frame_done=1 for one cycle, busy drops to 0 on the same edge.
- Window mapping (registered, updated on the same edge as the accept):
  - win(r,c) = post-shift chain[(K-1-r)*W + (K-1-c)].
  - The bottom-right element equals the din just accepted.
- Window valid:
  - win_valid=1 in the cycle after accepting a pixel with row>=K-1 and col>=K-1 (valid convolution, no padding).
  - Otherwise 0. win holds its last value when not updated.
  - Latency is 1 cycle. There are (W-K+1)*(H-K+1) strobes per frame.
- Row-wrap stale data: chain contents from the previous row or frame are never exposed, because windows are gated by col>=K-1 and row>=K-1. The chain is not flushed between frames.
- clear:
  - Has priority over in_valid in the same cycle; the pixel is dropped.
  - row=col=0, busy=0, cfg_err=0, win_valid=0, frame_done=0.
  - Chain and win are retained.
- Reset mid-frame: everything returns to reset values immediately; the next accepted pixel starts a new frame.
- Widths:
  - Tap index arithmetic is done in $clog2((K-1)*MAX_W+K) bits.
  - W*r uses the product of the constant r and W.
  - No multiplier is inferred beyond constant-times-W.

Optional Feature:
- Macro: BNN_WIN_STRIDE_EN.
- When defined:
  - Adds input port stride2 (1 bit), latched together with cfg_width.
  - With stride2=1, win_valid asserts only when (row-(K-1)) and (col-(K-1)) are both even. That gives ceil((W-K+1)/2)*ceil((H-K+1)/2) strobes per frame.
  - With stride2=0, behaviour is as above.
- When undefined: no stride2 port, stride 1 only.

Decomposition:
- Shared package bnn_win_pkg:
  - default K, MAX_W, MAX_H;
  - localparam chain depth function depth(K,MAX_W);
  - tap-index function tap(r,c,W);
  - typedef for the counter width.
- Sub-module bnn_win_ctrl:
  - row/col counters, config latch and check;
  - busy, frame_done, window-valid gating.
  - The datapath (chain plus tap mux) stays in the top module.

Test Plan:
- Basic window. CH=8, K=3, W=H=4, stream 0..15 back-to-back.
  - First win_valid follows pixel 10, with win={0,1,2,4,5,6,8,9,10}.
  - Further strobes after pixels 11, 14, 15.
  - frame_done with pixel 15; exactly 4 strobes.
- Gaps. Same stream with in_valid low for 3 cycles between every pixel.
  - Identical window contents and strobe count; no strobes during gaps.
- Width change and invalid config.
  - Run a W=28 frame, then a W=26 frame: windows correct, cfg change during busy ignored.
  - cfg_width=2: cfg_err=1, no shifting, busy=0.
  - Next pixel with W=4: cfg_err clears.
- Clear and reset mid-frame.
  - clear after pixel 7 together with in_valid: pixel dropped, busy=0.
  - A new 16-pixel frame then yields exactly the basic-window results.
  - Same test with rstn pulsed asynchronously mid-cycle.
- Back-to-back frames. Two 4x4 frames with no idle gap.
  - The second frame's first window is {16..18,20..22,24..26}.
  - No stale-data strobe at the frame boundary.
- Stride (BNN_WIN_STRIDE_EN). stride2=1, W=H=6, K=3, pixels 0..35.
  - Strobes after pixels 14, 16, 26, 28 only.

Source files
------------

// File: rtl/bnn_win_pkg.sv
// Shared definitions for the BNN line-window block.
// Contents:
//   DefK, DefMaxW, DefMaxH : default window size and frame bounds
//   cnt_t                  : row/column/config counter type
//   depth(k, max_w)        : delay-chain length needed for a KxK window
//   tap(r, c, w, k)        : chain index of window element (r, c) for line width w
package bnn_win_pkg;

  localparam int unsigned DefK    = 3;
  localparam int unsigned DefMaxW = 28;
  localparam int unsigned DefMaxH = 28;

  // Wide enough for any practical line width or frame height.
  localparam int unsigned CntBits = 16;
  typedef logic [CntBits-1:0] cnt_t;

  function automatic int unsigned depth(int unsigned k, int unsigned max_w);
    return (k - 1) * max_w + k;
  endfunction

  // r and c are elaboration constants at every call site, so the product is
  // only ever constant-times-w.
  function automatic int unsigned tap(int unsigned r, int unsigned c, int unsigned w,
                                      int unsigned k = DefK);
    return (k - 1 - r) * w + (k - 1 - c);
  endfunction

endpackage

// File: rtl/bnn_line_window_if.sv
// Pixel-stream / window bus of the BNN line window.
// Signals:
//   in_valid, din               : pixel strobe and pixel (producer -> window)
//   win, win_valid, frame_done  : KxK window, window strobe, end-of-frame pulse
// Modports: master = stream producer / window consumer, slave = line window.
interface bnn_line_window_if #(
  parameter int unsigned CH = 1,
  parameter int unsigned K  = 3
);
  logic              in_valid;
  logic [CH-1:0]     din;
  logic [K*K*CH-1:0] win;
  logic              win_valid;
  logic              frame_done;

  modport master (
    output in_valid, din,
    input  win, win_valid, frame_done
  );

  modport slave (
    input  in_valid, din,
    output win, win_valid, frame_done
  );
endinterface

// File: rtl/bnn_win_ctrl.sv
// Control path of the BNN line window: config latch and check, row/column
// tracking, busy, frame_done and window-valid gating.
// Optional macro BNN_WIN_STRIDE_EN adds the stride2 input (stride-2 windows).
// Ports:
//   clk, rstn               : clock, asynchronous active-low reset
//   clear                   : synchronous soft reset (drops any pixel)
//   in_valid                : pixel strobe
//   cfg_width, cfg_height   : requested W and H, sampled at frame start
//   stride2                 : (BNN_WIN_STRIDE_EN only) stride-2 select
//   accept                  : this cycle's pixel enters the chain
//   width                   : line width in force for this cycle's pixel
//   win_valid, frame_done   : registered strobes
//   busy, cfg_err           : frame in progress, latched config error
module bnn_win_ctrl
  import bnn_win_pkg::*;
#(
  parameter int unsigned K     = DefK,
  parameter int unsigned MAX_W = DefMaxW,
  parameter int unsigned MAX_H = DefMaxH,
  localparam int unsigned WBits = $clog2(MAX_W + 1),
  localparam int unsigned HBits = $clog2(MAX_H + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WBits-1:0] cfg_width,
  input  logic [HBits-1:0] cfg_height,
`ifdef BNN_WIN_STRIDE_EN
  input  logic             stride2,
`endif
  output logic             accept,
  output cnt_t             width,
  output logic             win_valid,
  output logic             frame_done,
  output logic             busy,
  output logic             cfg_err
);

  cnt_t w_q, h_q, row_q, col_q;
  cnt_t cfg_w, cfg_h, h_eff;
  logic cfg_ok, last_col, last_row, in_win, stride_ok;

`ifdef BNN_WIN_STRIDE_EN
  // (n - (K-1)) is even exactly when bit 0 of n matches the parity of K-1.
  localparam bit KParity = 1'((K - 1) % 2);
  logic stride_q, stride_eff;
`endif

  always_comb begin
    cfg_w    = cnt_t'(cfg_width);
    cfg_h    = cnt_t'(cfg_height);
    cfg_ok   = (cfg_w >= cnt_t'(K)) && (cfg_w <= cnt_t'(MAX_W)) &&
               (cfg_h >= cnt_t'(K)) && (cfg_h <= cnt_t'(MAX_H));
    // The first pixel of a frame already uses the config being latched.
    width    = busy ? w_q : cfg_w;
    h_eff    = busy ? h_q : cfg_h;
    accept   = in_valid && !clear && (busy || cfg_ok);
    last_col = (col_q == width - cnt_t'(1));
    last_row = (row_q == h_eff - cnt_t'(1));
    in_win   = (row_q >= cnt_t'(K - 1)) && (col_q >= cnt_t'(K - 1));
    stride_ok = 1'b1;
`ifdef BNN_WIN_STRIDE_EN
    stride_eff = busy ? stride_q : stride2;
    if (stride_eff) begin
      stride_ok = (row_q[0] == KParity) && (col_q[0] == KParity);
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_q        <= '0;
      h_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      busy       <= 1'b0;
      cfg_err    <= 1'b0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
`ifdef BNN_WIN_STRIDE_EN
      stride_q   <= 1'b0;
`endif
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (clear) begin
        row_q   <= '0;
        col_q   <= '0;
        busy    <= 1'b0;
        cfg_err <= 1'b0;
      end else if (in_valid) begin
        if (!busy) begin
          cfg_err <= !cfg_ok;
        end
        if (accept) begin
          if (!busy) begin
            w_q <= cfg_w;
            h_q <= cfg_h;
`ifdef BNN_WIN_STRIDE_EN
            stride_q <= stride2;
`endif
          end
          win_valid <= in_win && stride_ok;
          if (last_col) begin
            col_q <= '0;
            if (last_row) begin
              row_q      <= '0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              row_q <= row_q + cnt_t'(1);
              busy  <= 1'b1;
            end
          end else begin
            col_q <= col_q + cnt_t'(1);
            busy  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/bnn_line_window.sv
// Streaming line buffer: turns a raster-order pixel stream into a KxK sliding
// window for the binary convolution engine.
// Optional macro BNN_WIN_STRIDE_EN adds the stride2 input (stride-2 windows).
// Ports:
//   clk, rstn               : clock, asynchronous active-low reset
//   clear                   : synchronous soft reset; chain and win are kept
//   cfg_width, cfg_height   : line width W and frame height H
//   stride2                 : (BNN_WIN_STRIDE_EN only) stride-2 select
//   bus                     : pixel in / window out (slave modport)
//   busy                    : frame in progress
//   cfg_err                 : latched config invalid
module bnn_line_window
  import bnn_win_pkg::*;
#(
  parameter int unsigned CH    = 1,
  parameter int unsigned K     = DefK,
  parameter int unsigned MAX_W = DefMaxW,
  parameter int unsigned MAX_H = DefMaxH,
  localparam int unsigned WBits = $clog2(MAX_W + 1),
  localparam int unsigned HBits = $clog2(MAX_H + 1)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clear,
  input  logic [WBits-1:0]     cfg_width,
  input  logic [HBits-1:0]     cfg_height,
`ifdef BNN_WIN_STRIDE_EN
  input  logic                 stride2,
`endif
  bnn_line_window_if.slave     bus,
  output logic                 busy,
  output logic                 cfg_err
);

  localparam int unsigned Depth   = depth(K, MAX_W);
  localparam int unsigned IdxBits = $clog2(Depth);

  logic [CH-1:0]      chain_q [Depth];
  logic [CH-1:0]      chain_d [Depth];
  logic [IdxBits-1:0] idx     [K*K];
  logic [K*K*CH-1:0]  win_q, win_d;
  logic               accept, win_valid, frame_done;
  cnt_t               width;

  bnn_win_ctrl #(
    .K     (K),
    .MAX_W (MAX_W),
    .MAX_H (MAX_H)
  ) u_ctrl (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (clear),
    .in_valid   (bus.in_valid),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
`ifdef BNN_WIN_STRIDE_EN
    .stride2    (stride2),
`endif
    .accept     (accept),
    .width      (width),
    .win_valid  (win_valid),
    .frame_done (frame_done),
    .busy       (busy),
    .cfg_err    (cfg_err)
  );

  // Post-shift view of the chain, so the window taps what the edge will store.
  always_comb begin
    chain_d[0] = bus.din;
    for (int i = 1; i < Depth; i++) begin
      chain_d[i] = chain_q[i-1];
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      assign idx[r*K+c] = IdxBits'(tap(r, c, 32'(width), K));
    end
  end

  always_comb begin
    win_d = '0;
    for (int e = 0; e < K * K; e++) begin
      win_d[e*CH +: CH] = chain_d[idx[e]];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < Depth; i++) begin
        chain_q[i] <= '0;
      end
      win_q <= '0;
    end else if (accept) begin
      chain_q <= chain_d;
      win_q   <= win_d;
    end
  end

  assign bus.win        = win_q;
  assign bus.win_valid  = win_valid;
  assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_bnn_line_window.sv
// Self-checking bench for bnn_line_window (CH=8, K=3, 28x28 bounds).
// The reference model keeps the current frame as a 2-D image and cuts each
// expected window straight out of it.
module tb_bnn_line_window;
  localparam int CH = 8;
  localparam int K = 3;
  localparam int MAX_W = 28;
  localparam int MAX_H = 28;
  localparam int WB = K * K * CH;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       clear = 1'b0;
  logic [4:0] cfg_width = 5'd4;
  logic [4:0] cfg_height = 5'd4;
  logic       stride2 = 1'b0;
  logic       busy, cfg_err;

  bnn_line_window_if #(.CH(CH), .K(K)) bus ();

  bnn_line_window #(
    .CH    (CH),
    .K     (K),
    .MAX_W (MAX_W),
    .MAX_H (MAX_H)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (clear),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
`ifdef BNN_WIN_STRIDE_EN
    .stride2    (stride2),
`endif
    .bus        (bus),
    .busy       (busy),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  int          m_row, m_col, m_w, m_h;
  bit          m_busy, m_err, m_stride;
  bit          exp_wv, exp_fd;
  logic [WB-1:0] exp_win;
  logic [CH-1:0] img [MAX_H][MAX_W];

  int            strobes;
  bit            first_seen;
  logic [WB-1:0] first_win;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_row = 0; m_col = 0; m_busy = 0; m_err = 0;
  endtask

  task automatic model_step(input bit v, input bit clr, input logic [CH-1:0] px);
    bit acc, ok;
    exp_wv = 0;
    exp_fd = 0;
    if (clr) begin
      model_reset();
    end else if (v) begin
      acc = m_busy;
      if (!m_busy) begin
        ok = (cfg_width >= K) && (cfg_width <= MAX_W) &&
             (cfg_height >= K) && (cfg_height <= MAX_H);
        m_err = !ok;
        acc = ok;
        if (ok) begin
          m_w = int'(cfg_width);
          m_h = int'(cfg_height);
`ifdef BNN_WIN_STRIDE_EN
          m_stride = stride2;
`else
          m_stride = 0;
`endif
        end
      end
      if (acc) begin
        img[m_row][m_col] = px;
        if (m_row >= K - 1 && m_col >= K - 1 &&
            (!m_stride || (((m_row - (K - 1)) % 2 == 0) && ((m_col - (K - 1)) % 2 == 0)))) begin
          exp_wv = 1;
          for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
              exp_win[(r*K+c)*CH +: CH] = img[m_row-(K-1)+r][m_col-(K-1)+c];
        end
        m_busy = 1;
        if (m_col == m_w - 1) begin
          m_col = 0;
          if (m_row == m_h - 1) begin
            m_row = 0;
            m_busy = 0;
            exp_fd = 1;
          end else begin
            m_row++;
          end
        end else begin
          m_col++;
        end
      end
    end
  endtask

  // Drive one cycle, then compare every output against the model.
  task automatic cycle(input bit v, input bit clr, input logic [CH-1:0] px);
    bus.in_valid = v;
    bus.din = px;
    clear = clr;
    @(posedge clk);
    #1;
    model_step(v, clr, px);
    check("win_valid", 128'(bus.win_valid), 128'(exp_wv));
    check("frame_done", 128'(bus.frame_done), 128'(exp_fd));
    check("busy", 128'(busy), 128'(m_busy));
    check("cfg_err", 128'(cfg_err), 128'(m_err));
    if (exp_wv) check("win", 128'(bus.win), 128'(exp_win));
    if (bus.win_valid === 1'b1) begin
      strobes++;
      if (!first_seen) begin
        first_seen = 1;
        first_win = bus.win;
      end
    end
    bus.in_valid = 1'b0;
    clear = 1'b0;
  endtask

  // One full frame; pixels are base+i or random, gaps drawn from [glo, ghi].
  task automatic frame(input int w, input int h, input int glo, input int ghi,
                       input bit rnd_px, input int base, input bit rnd_cfg);
    int exp_n;
    cfg_width = 5'(w);
    cfg_height = 5'(h);
    strobes = 0;
    first_seen = 0;
    for (int i = 0; i < w * h; i++) begin
      cycle(1'b1, 1'b0, rnd_px ? 8'($urandom) : 8'(base + i));
      if (rnd_cfg) begin
        cfg_width = 5'($urandom);
        cfg_height = 5'($urandom);
      end
      repeat ($urandom_range(ghi, glo)) cycle(1'b0, 1'b0, 8'($urandom));
    end
    if (stride2) exp_n = ((w - K + 2) / 2) * ((h - K + 2) / 2);
    else exp_n = (w - K + 1) * (h - K + 1);
    check("strobe_count", 128'(strobes), 128'(exp_n));
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.din = '0;
    model_reset();
    #2;
    check("rst_win", 128'(bus.win), 128'(0));
    check("rst_win_valid", 128'(bus.win_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_cfg_err", 128'(cfg_err), 128'(0));
    #8 rstn = 1'b1;
    @(posedge clk);
    #1;

    // Basic window, back-to-back pixels 0..15.
    frame(4, 4, 0, 0, 0, 0, 0);
    check("basic_first_win", 128'(first_win), 128'(72'h0a_09_08_06_05_04_02_01_00));

    // Same stream with 3 idle cycles after every pixel.
    frame(4, 4, 3, 3, 0, 0, 0);
    check("gap_first_win", 128'(first_win), 128'(72'h0a_09_08_06_05_04_02_01_00));

    // Wide frames with random pixels, gaps and config churn while busy.
    frame(28, 4, 0, 2, 1, 0, 1);
    frame(26, 5, 0, 2, 1, 0, 1);
    frame(4, 28, 0, 1, 1, 0, 0);

    // Invalid configs: pixel dropped, cfg_err latched, busy stays low.
    cfg_width = 5'd2;
    cfg_height = 5'd4;
    cycle(1'b1, 1'b0, 8'($urandom));
    check("inv_w_err", 128'(cfg_err), 128'(1));
    cycle(1'b0, 1'b0, 8'h00);
    cfg_width = 5'd4;
    cfg_height = 5'd29;
    cycle(1'b1, 1'b0, 8'($urandom));
    check("inv_h_busy", 128'(busy), 128'(0));
    frame(4, 4, 0, 0, 0, 0, 0);
    check("inv_recover_err", 128'(cfg_err), 128'(0));
    check("inv_recover_win", 128'(first_win), 128'(72'h0a_09_08_06_05_04_02_01_00));

    // clear together with pixel 7.
    cfg_width = 5'd4;
    cfg_height = 5'd4;
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 8'(100 + i));
    cycle(1'b1, 1'b1, 8'd107);
    check("clear_busy", 128'(busy), 128'(0));
    frame(4, 4, 0, 0, 0, 0, 0);
    check("clear_first_win", 128'(first_win), 128'(72'h0a_09_08_06_05_04_02_01_00));

    // Asynchronous reset mid-cycle, mid-frame.
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 8'(200 + i));
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check("arst_win", 128'(bus.win), 128'(0));
    check("arst_busy", 128'(busy), 128'(0));
    check("arst_win_valid", 128'(bus.win_valid), 128'(0));
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;
    frame(4, 4, 0, 0, 0, 0, 0);
    check("arst_first_win", 128'(first_win), 128'(72'h0a_09_08_06_05_04_02_01_00));

    // Back-to-back frames, no idle cycle between them.
    frame(4, 4, 0, 0, 0, 0, 0);
    frame(4, 4, 0, 0, 0, 16, 0);
    check("b2b_first_win", 128'(first_win), 128'(72'h1a_19_18_16_15_14_12_11_10));

`ifdef BNN_WIN_STRIDE_EN
    stride2 = 1'b1;
    frame(6, 6, 0, 0, 0, 0, 0);
    frame(7, 5, 0, 2, 1, 0, 0);
    stride2 = 1'b0;
    frame(5, 5, 0, 1, 1, 0, 0);
`endif

    repeat (3) cycle(1'b0, 1'b0, 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
